key_schedule_ctrl: RTL and testbench

- Sequential controller around the combinational `key_schedule` datapath (56-bit C||D rotate plus PC2).
- Loads a post-PC1 56-bit key and iterates the 16 DES rounds, one per cycle, using the standard shift table.
- Buffers all 16 48-bit subkeys, then streams them to the round engine over a valid/ready handshake.
- Streams K1..K16 for encryption and K16..K1 for decryption, so the round engine needs no rotate-right path.

---
 rtl/des_pkg.sv | 19 +
 rtl/key_schedule.sv | 36 +++
 rtl/subkey_buf.sv | 22 ++
 rtl/key_schedule_ctrl.sv | 125 ++++++++++++
 tb/tb_key_schedule_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: shift table, controller states, widths.
package des_pkg;

  localparam int unsigned KEY56_W  = 56;
  localparam int unsigned SUBKEY_W = 48;

  // Left-rotate amount applied to C and D before each round's PC2
  localparam logic [3:0] SHIFT [16] = '{
    4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2,
    4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    SERVE
  } state_t;

endpackage

// File: rtl/key_schedule.sv
// Combinational DES key-schedule step: rotate C and D left by i, then PC2.
module key_schedule
  import des_pkg::*;
(
  input  logic [KEY56_W-1:0]  x,
  input  logic [3:0]          i,
  output logic [KEY56_W-1:0]  r,
  output logic [SUBKEY_W-1:0] k
);

  // PC2 selection, 1-based bit positions counted from the MSB of C||D
  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic [27:0] c, d;

  // Rotate each 28-bit half left by one or two places
  always_comb begin
    c = x[55:28];
    d = x[27:0];
    if (i == 4'd2) begin
      r = {c[25:0], c[27:26], d[25:0], d[27:26]};
    end else begin
      r = {c[26:0], c[27], d[26:0], d[27]};
    end
  end

  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign k[47-j] = r[56-PC2[j]];
  end

endmodule

// File: rtl/subkey_buf.sv
// 16x48 subkey register file: one synchronous write port, one async read port.
module subkey_buf
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [3:0]          waddr,
  input  logic [SUBKEY_W-1:0] wdata,
  input  logic [3:0]          raddr,
  output logic [SUBKEY_W-1:0] rdata
);

  logic [SUBKEY_W-1:0] mem [16];

  // Contents are deliberately not reset; readers gate them with valid
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/key_schedule_ctrl.sv
// DES key-schedule controller: expands a post-PC1 key into 16 buffered
// subkeys, then streams them K1..K16 (encrypt) or K16..K1 (decrypt) over
// a valid/ready handshake.
// Optional feature macro: KS_ABORT_EN (key_load while busy restarts).
module key_schedule_ctrl
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY56_W-1:0]  key_in,
  input  logic                key_load,
  input  logic                dec,
  output logic                busy,
  output logic [SUBKEY_W-1:0] subkey,
  output logic [3:0]          subkey_round,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic                done
);

  if (ROUNDS != 16) begin : g_rounds_check
    $error("key_schedule_ctrl supports ROUNDS = 16 only");
  end

  state_t               state, state_n;
  logic [KEY56_W-1:0]   cd_reg, cd_next;
  logic [SUBKEY_W-1:0]  round_key, rd_key;
  logic                 dir;
  logic [3:0]           rnd, ptr, cnt;
  logic                 done_r;
  logic                 start, abort, xfer, last_rnd, last_xfer;

  key_schedule u_ks (
    .x (cd_reg),
    .i (SHIFT[rnd]),
    .r (cd_next),
    .k (round_key)
  );

  subkey_buf u_subkey_buf (
    .clk   (clk),
    .we    ((state == EXPAND) && !abort),
    .waddr (rnd),
    .wdata (round_key),
    .raddr (ptr),
    .rdata (rd_key)
  );

  // Control decode and next-state selection; a restart overrides the FSM
  always_comb begin
    start     = (state == IDLE) && key_load;
`ifdef KS_ABORT_EN
    abort     = (state != IDLE) && key_load;
`else
    abort     = 1'b0;
`endif
    xfer      = (state == SERVE) && subkey_ready;
    last_rnd  = (rnd == 4'd15);
    last_xfer = xfer && (cnt == 4'd15);
    state_n   = state;
    case (state)
      IDLE:    if (key_load)  state_n = EXPAND;
      EXPAND:  if (last_rnd)  state_n = SERVE;
      SERVE:   if (last_xfer) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = EXPAND;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Round/pointer/count registers and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_reg <= '0;
      dir    <= 1'b0;
      rnd    <= '0;
      ptr    <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start || abort) begin
        cd_reg <= key_in;
        dir    <= dec;
        rnd    <= '0;
      end else begin
        case (state)
          EXPAND: begin
            cd_reg <= cd_next;
            rnd    <= rnd + 4'd1;
            if (last_rnd) begin
              ptr <= dir ? 4'd15 : 4'd0;
              cnt <= '0;
            end
          end
          SERVE: begin
            if (xfer) begin
              ptr <= dir ? ptr - 4'd1 : ptr + 4'd1;
              cnt <= cnt + 4'd1;
              if (cnt == 4'd15) done_r <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output decode; subkey is masked whenever nothing is presented
  always_comb begin
    busy         = (state != IDLE);
    subkey_valid = (state == SERVE);
    subkey       = subkey_valid ? rd_key : '0;
    subkey_round = subkey_valid ? ptr : '0;
    done         = done_r;
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl (KS_ABORT_EN selects abort checks).
module tb_key_schedule_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [55:0] key_in;
  logic        key_load;
  logic        dec;
  logic        busy;
  logic [47:0] subkey;
  logic [3:0]  subkey_round;
  logic        subkey_valid;
  logic        subkey_ready;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [55:0] KEY_A = 56'hF0CCAAF556678F;
  localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

  int sh [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  key_schedule_ctrl #(.ROUNDS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_load     (key_load),
    .dec          (dec),
    .busy         (busy),
    .subkey       (subkey),
    .subkey_round (subkey_round),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Subkey n (0-based) from the cumulative rotation of C and D, then PC2
  function automatic logic [47:0] model_key(input logic [55:0] key, input int n);
    int s = 0;
    logic [55:0] tc, td, cd;
    logic [47:0] k;
    for (int j = 0; j <= n; j++) s += sh[j];
    tc = {key[55:28], key[55:28]} << s;
    td = {key[27:0], key[27:0]} << s;
    cd = {tc[55:28], td[55:28]};
    for (int j = 0; j < 48; j++) k[47-j] = cd[56-pc2[j]];
    return k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the load edge
  task automatic load(input logic [55:0] key, input logic d);
    key_in   = key;
    dec      = d;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic wait_valid(output int n, output bit saw_done);
    n = 0;
    saw_done = 0;
    while (!subkey_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (done) saw_done = 1;
    end
  endtask

  // Consume stop_after transfers; returns at the negedge after the last one
  task automatic serve(input logic [55:0] key, input logic d, input bit rand_rdy,
                       input int stop_after, output logic [47:0] first_k,
                       output logic [47:0] last_k);
    int cyc = 0;
    int got = 0;
    int er;
    bit held = 0;
    logic [47:0] hk;
    logic [3:0]  hr;
    first_k = '0;
    last_k  = '0;
    while (got < stop_after && cyc < 400) begin
      if (!subkey_valid) begin
        chk("valid_dropped_early", {63'd0, subkey_valid}, 64'd1);
        break;
      end
      if (held) begin
        chk("hold_subkey", {16'd0, subkey}, {16'd0, hk});
        chk("hold_round", {60'd0, subkey_round}, {60'd0, hr});
      end
      subkey_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (subkey_ready) begin
        er = d ? 15 - got : got;
        chk("xfer_round", {60'd0, subkey_round}, 64'(er));
        chk("xfer_subkey", {16'd0, subkey}, {16'd0, model_key(key, er)});
        if (got == 0) first_k = subkey;
        last_k = subkey;
        got++;
        held = 0;
      end else begin
        held = 1;
        hk = subkey;
        hr = subkey_round;
      end
      @(negedge clk);
      cyc++;
    end
    subkey_ready = 1'b0;
    chk("serve_count", 64'(got), 64'(stop_after));
  endtask

  // Full schedule from a negedge; returns in the done cycle
  task automatic full(input logic [55:0] key, input logic d, input bit rand_rdy);
    int n;
    bit sd;
    logic [47:0] fk, lk;
    load(key, d);
    chk("busy_after_load", {63'd0, busy}, 64'd1);
    wait_valid(n, sd);
    chk("valid_latency", 64'(n), 64'd16);
    chk("cd_after_expand", {8'd0, dut.cd_reg}, {8'd0, key});
    serve(key, d, rand_rdy, 16, fk, lk);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("valid_after_done", {63'd0, subkey_valid}, 64'd0);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n;
    bit sd;
    logic [47:0] fk, lk;
    logic [55:0] kb;

    rst = 1'b1; key_in = '0; key_load = 1'b0; dec = 1'b0; subkey_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, subkey_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_subkey", {16'd0, subkey}, 64'd0);
    chk("rst_round", {60'd0, subkey_round}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Encrypt known vector with ready held high
    load(KEY_A, 1'b0);
    wait_valid(n, sd);
    chk("enc_latency", 64'(n), 64'd16);
    chk("enc_cd_after_expand", {8'd0, dut.cd_reg}, {8'd0, KEY_A});
    serve(KEY_A, 1'b0, 1'b0, 16, fk, lk);
    chk("enc_first_k1", {16'd0, fk}, {16'd0, K1_A});
    chk("enc_last_k16", {16'd0, lk}, {16'd0, K16_A});
    chk("enc_done", {63'd0, done}, 64'd1);
    @(negedge clk);
    chk("enc_done_one_cycle", {63'd0, done}, 64'd0);

    // Decrypt same key
    load(KEY_A, 1'b1);
    wait_valid(n, sd);
    chk("dec_latency", 64'(n), 64'd16);
    serve(KEY_A, 1'b1, 1'b0, 16, fk, lk);
    chk("dec_first_k16", {16'd0, fk}, {16'd0, K16_A});
    chk("dec_last_k1", {16'd0, lk}, {16'd0, K1_A});
    chk("dec_done", {63'd0, done}, 64'd1);
    @(negedge clk);

    // Random keys with random backpressure
    for (int t = 0; t < 4; t++) begin
      kb = {24'($urandom), $urandom};
      full(kb, 1'(t), 1'b1);
      @(negedge clk);
      chk("rand_done_drop", {63'd0, done}, 64'd0);
    end

    // Reset after 5 transfers
    load(KEY_A, 1'b0);
    wait_valid(n, sd);
    serve(KEY_A, 1'b0, 1'b0, 5, fk, lk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {63'd0, subkey_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    subkey_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_no_valid", {63'd0, subkey_valid}, 64'd0);
    subkey_ready = 1'b0;
    kb = {24'($urandom), $urandom};
    full(kb, 1'b0, 1'b0);
    @(negedge clk);

    // key_load during EXPAND
    kb = {24'($urandom), $urandom};
    load(KEY_A, 1'b0);
    repeat (4) @(negedge clk);
    load(kb, 1'b1);
`ifdef KS_ABORT_EN
    wait_valid(n, sd);
    chk("abort_latency", 64'(n), 64'd16);
    chk("abort_no_old_done", {63'd0, sd}, 64'd0);
    serve(kb, 1'b1, 1'b0, 16, fk, lk);
    chk("abort_done", {63'd0, done}, 64'd1);
`else
    chk("ignore_busy", {63'd0, busy}, 64'd1);
    wait_valid(n, sd);
    chk("ignore_latency", 64'(n + 5), 64'd16);
    serve(KEY_A, 1'b0, 1'b0, 16, fk, lk);
    chk("ignore_first_k1", {16'd0, fk}, {16'd0, K1_A});
    chk("ignore_done", {63'd0, done}, 64'd1);
`endif
    @(negedge clk);

    // Back-to-back: second load issued in the done cycle
    full(KEY_A, 1'b1, 1'b0);
    kb = {24'($urandom), $urandom};
    full(kb, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_done_drop", {63'd0, done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
